// File: rtl/axi_mem_dp_arb_pkg.sv
// Shared types and constants for the dual-port memory arbiter and its rotating priority picker.
// The port-index width helper keeps a one-bit index even for degenerate port counts.
package axi_mem_dp_arb_pkg;

    localparam int N_PORTS_DEFAULT = 2;

    // Idle memory command values; both memory strobes are active-low.
    localparam logic CEN_IDLE = 1'b1;
    localparam logic WEN_READ = 1'b1;

    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    typedef logic [idx_width(N_PORTS_DEFAULT)-1:0] port_idx_t;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Rotating-priority find: returns the first requester at or after start, wrapping modulo N.
// The result is a one-hot grant and the matching index; both are zero when nothing requests.
module mem_arb_rr_pick
    import axi_mem_dp_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    always_comb begin
        int  p;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        p     = 0;
        for (int k = 0; k < N; k++) begin
            p = (int'(start) + k) % N;
            if (!found && req[p]) begin
                found    = 1'b1;
                grant[p] = 1'b1;
                idx      = IW'(p);
            end
        end
    end

endmodule

// File: rtl/axi_mem_dp_arbiter.sv
// Round-robin arbiter with bounded hold sharing one single-port, 1-cycle-latency memory
// between N_PORTS controllers; returns a registered read-valid tagged to the winning port.
module axi_mem_dp_arbiter
    import axi_mem_dp_arb_pkg::*;
#(
    parameter int N_PORTS        = 2,
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int DATA_WIDTH     = 64,
    parameter int BE_WIDTH       = DATA_WIDTH / 8,
    parameter int MAX_HOLD       = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_PORTS-1:0]             req_valid_i,
    input  logic [N_PORTS-1:0]             req_wen_i,
    input  logic [N_PORTS*MEM_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [N_PORTS*DATA_WIDTH-1:0]  req_wdata_i,
    input  logic [N_PORTS*BE_WIDTH-1:0]    req_be_i,
    output logic [N_PORTS-1:0]             grant_o,
    output logic [N_PORTS-1:0]             rvalid_o,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic                           MEM_CEN_o,
    output logic                           MEM_WEN_o,
    output logic [MEM_ADDR_WIDTH-1:0]      MEM_A_o,
    output logic [DATA_WIDTH-1:0]          MEM_D_o,
    output logic [BE_WIDTH-1:0]            MEM_BE_o,
    input  logic [DATA_WIDTH-1:0]          MEM_Q_i
);

    localparam int IW = idx_width(N_PORTS);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    logic [IW-1:0]      owner;
    logic [IW-1:0]      start;
    logic [IW-1:0]      pick_idx;
    logic [IW-1:0]      win_idx;
    logic [HW-1:0]      hold_cnt;
    logic [N_PORTS-1:0] rd_pend;
    logic [N_PORTS-1:0] req;
    logic [N_PORTS-1:0] pick_grant;
    logic               keep;
    logic               any_grant;

    // Reset masks requests so grant_o falls immediately, not at the next edge.
    assign req = rst ? '0 : req_valid_i;

    // A streak only continues from a granted cycle (hold_cnt != 0); after an idle
    // cycle or reset the scan restarts just past the last owner.
    assign keep  = req[owner] && (hold_cnt != '0) && (hold_cnt < HOLD_MAX);
    assign start = (int'(owner) == N_PORTS - 1) ? '0 : owner + 1'b1;

    mem_arb_rr_pick #(
        .N  (N_PORTS),
        .IW (IW)
    ) u_pick (
        .req   (req),
        .start (start),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    always_comb begin
        grant_o = '0;
        win_idx = pick_idx;
        if (keep) begin
            win_idx        = owner;
            grant_o[owner] = 1'b1;
        end else begin
            grant_o = pick_grant;
        end
    end

    assign any_grant = |grant_o;

    always_comb begin
        MEM_CEN_o = CEN_IDLE;
        MEM_WEN_o = WEN_READ;
        MEM_A_o   = '0;
        MEM_D_o   = '0;
        MEM_BE_o  = '0;
        if (any_grant) begin
            MEM_CEN_o = ~CEN_IDLE;
            MEM_WEN_o = req_wen_i[win_idx];
            MEM_A_o   = req_addr_i[int'(win_idx)*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
            MEM_D_o   = req_wdata_i[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
            MEM_BE_o  = req_be_i[int'(win_idx)*BE_WIDTH +: BE_WIDTH];
        end
    end

    // keep implies hold_cnt < MAX_HOLD, so the increment never overflows; a re-win
    // after the limit (sole requester) goes through the reload branch instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner    <= '0;
            hold_cnt <= '0;
            rd_pend  <= '0;
        end else begin
            rd_pend <= grant_o & {N_PORTS{MEM_WEN_o == WEN_READ}};
            if (keep) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else if (any_grant) begin
                owner    <= win_idx;
                hold_cnt <= HW'(1);
            end else begin
                hold_cnt <= '0;
            end
        end
    end

    assign rvalid_o = rd_pend;
    assign rdata_o  = MEM_Q_i;

endmodule
